// File: rtl/duty_ramp_if.sv
// ---------------------------------------------------------------------------
// duty_ramp_if
//   Target handshake bundle between a brightness producer and duty_ramp.
//
//   Handshake: the producer raises target_valid and holds target stable until
//   an edge where target_valid & target_ready are both high. That edge is the
//   transfer. The consumer asserts target_ready only while it can accept.
//   A valid seen while ready is low is ignored and not queued.
//
//   Signals
//     target        N   requested final duty
//     target_valid  1   target is offered
//     target_ready  1   consumer can accept a target
//
//   Modports
//     master  producer side (drives target/target_valid)
//     slave   duty_ramp side (drives target_ready)
// ---------------------------------------------------------------------------
interface duty_ramp_if #(
    parameter int N = 8
) ();
    logic [N-1:0] target;
    logic         target_valid;
    logic         target_ready;

    modport master (
        output target,
        output target_valid,
        input  target_ready
    );

    modport slave (
        input  target,
        input  target_valid,
        output target_ready
    );
endinterface

// File: rtl/duty_ramp.sv
// ---------------------------------------------------------------------------
// duty_ramp
//   Upstream driver for a PWM stage. It generates a prescaled step pulse and
//   a duty value that moves one LSB at a time toward an accepted brightness
//   target. This gives smooth LED fades instead of abrupt duty jumps.
//
//   Parameters
//     N           duty width (must match the downstream PWM)
//     PRESCALE    clk cycles per step pulse (>=1)
//     RAMP_TICKS  step pulses per 1-LSB duty change (>=1)
//
//   Ports
//     clk        in   system clock
//     rst        in   synchronous, active-high reset
//     ena        in   global enable; low freezes prescaler, ramp counter, duty
//     tgt_if     slave side of the target handshake (target/valid/ready)
//     duty       out  current duty to PWM (registered)
//     step       out  one-cycle step pulse to PWM (registered)
//     busy       out  ramp in progress (UP or DOWN)
//     done       out  one-cycle pulse when duty reaches the accepted target
//     dbg_state  out  current FSM state encoding
// ---------------------------------------------------------------------------
module duty_ramp #(
    parameter int N          = 8,
    parameter int PRESCALE   = 100,
    parameter int RAMP_TICKS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    duty_ramp_if.slave   tgt_if,
    output logic [N-1:0] duty,
    output logic         step,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);

    // Counter widths kept at least 1 bit so PRESCALE/RAMP_TICKS of 1 work.
    localparam int PW = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] RMAX = RW'(RAMP_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q,  pcnt_d;
    logic [RW-1:0] rcnt_q,  rcnt_d;
    logic [N-1:0]  duty_q,  duty_d;
    logic [N-1:0]  goal_q,  goal_d;
    logic          step_q,  step_d;
    logic [N-1:0]  duty_next;

    // Neighbour value in the ramp direction. Only used in UP/DOWN, where
    // duty is strictly short of goal, so this can never wrap.
    assign duty_next = (state_q == ST_UP) ? (duty_q + N'(1)) : (duty_q - N'(1));

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        rcnt_d  = rcnt_q;
        duty_d  = duty_q;
        goal_d  = goal_q;
        step_d  = 1'b0;

        // Prescaler runs in every state so the PWM pace is independent of ramping.
        if (ena) begin
            if (pcnt_q == PMAX) begin
                pcnt_d = '0;
                step_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                // Acceptance is deliberately independent of ena.
                if (tgt_if.target_valid) begin
                    goal_d = tgt_if.target;
                    rcnt_d = '0;
                    if (tgt_if.target > duty_q)      state_d = ST_UP;
                    else if (tgt_if.target < duty_q) state_d = ST_DOWN;
                    else                             state_d = ST_DONE;
                end
            end
            ST_UP, ST_DOWN: begin
                // Ramp advances on the registered step pulse, gated by ena.
                if (step_q && ena) begin
                    if (rcnt_q == RMAX) begin
                        rcnt_d = '0;
                        duty_d = duty_next;
                        if (duty_next == goal_q) state_d = ST_DONE;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            rcnt_q  <= '0;
            duty_q  <= '0;
            goal_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            rcnt_q  <= rcnt_d;
            duty_q  <= duty_d;
            goal_q  <= goal_d;
            step_q  <= step_d;
        end
    end

    assign duty                = duty_q;
    assign step                = step_q;
    assign busy                = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign done                = (state_q == ST_DONE);
    assign tgt_if.target_ready = (state_q == ST_IDLE);
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_duty_ramp.sv
// ---------------------------------------------------------------------------
// tb_duty_ramp
//   Directed and randomized checks of duty_ramp with N=4, PRESCALE=4,
//   RAMP_TICKS=2. The reference model counts enabled cycles and consumed step
//   pulses and derives duty arithmetically: start +/- pulses/RAMP_TICKS,
//   clipped at the goal.
// ---------------------------------------------------------------------------
module tb_duty_ramp;
    localparam int N  = 4;
    localparam int P  = 4;
    localparam int RT = 2;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [N-1:0] duty;
    logic         step;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    duty_ramp_if #(.N(N)) tif ();

    duty_ramp #(
        .N(N), .PRESCALE(P), .RAMP_TICKS(RT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .tgt_if    (tif.slave),
        .duty      (duty),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [N-1:0] exp_q[$];

    // Reference model: mode 0 = idle, 1 = ramping, 2 = done pulse
    int   m_en_cnt, m_mode, m_start, m_goal, m_pulses, m_duty;
    logic m_step;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic v, input logic [N-1:0] t);
        logic used;
        int   moved;
        if (r) begin
            m_en_cnt = 0; m_step = 1'b0; m_mode = 0;
            m_start = 0; m_goal = 0; m_pulses = 0; m_duty = 0;
        end else begin
            used = m_step && e;
            case (m_mode)
                0: if (v) begin
                    m_start = m_duty; m_goal = int'(t); m_pulses = 0;
                    m_mode = (int'(t) == m_duty) ? 2 : 1;
                end
                1: if (used) begin
                    m_pulses++;
                    moved  = m_pulses / RT;
                    m_duty = (m_goal > m_start) ? m_start + moved : m_start - moved;
                    if (m_duty == m_goal) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
            if (e) begin
                m_en_cnt++;
                m_step = ((m_en_cnt % P) == 0);
            end else begin
                m_step = 1'b0;
            end
        end
        exp_q.push_back(N'(m_duty));
    endtask

    task automatic check_outputs();
        chk("duty",  32'(duty), 32'(exp_q.pop_front()));
        chk("step",  32'(step), 32'(m_step));
        chk("busy",  32'(busy), 32'(m_mode == 1));
        chk("done",  32'(done), 32'(m_mode == 2));
        chk("ready", 32'(tif.target_ready), 32'(m_mode == 0));
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic r, input logic e, input logic v, input logic [N-1:0] t);
        rst = r; ena = e; tif.target_valid = v; tif.target = t;
        @(posedge clk);
        model_edge(r, e, v, t);
        #1;
        check_outputs();
    endtask

    // Offer a target for one cycle, then run enabled until the model is idle.
    task automatic run_ramp(input string tag, input logic [N-1:0] t, input int budget,
                            output int busy_seen, output int max_jump, output int done_next);
        int n;
        int prev;
        int d;
        busy_seen = 0; max_jump = 0;
        prev = int'(duty);
        tick(1'b0, 1'b1, 1'b1, t);
        done_next = int'(done);
        n = 0;
        while (m_mode != 0 && n < budget) begin
            if (busy) busy_seen = 1;
            d = int'(duty) - prev; if (d < 0) d = -d;
            if (d > max_jump) max_jump = d;
            prev = int'(duty);
            tick(1'b0, 1'b1, 1'b0, '0);
            n++;
        end
        d = int'(duty) - prev; if (d < 0) d = -d;
        if (d > max_jump) max_jump = d;
        chk({tag, "_ready"}, 32'(tif.target_ready), 32'd1);
        chk({tag, "_duty"},  32'(duty), 32'(t));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int sc, bs, mj, dn, n, last, ready_cnt;
        int chg[$];
        int hi[$];

        // 1: reset
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        chk("rst_duty",  32'(duty), 32'd0);
        chk("rst_step",  32'(step), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_ready", 32'(tif.target_ready), 32'd1);

        // 2: step cadence, freeze, resume
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            if (step) hi.push_back(i);
        end
        chk("step_cnt_12", 32'(hi.size()), 32'd3);
        if (hi.size() == 3) begin
            chk("step_gap_a", 32'(hi[1] - hi[0]), 32'd4);
            chk("step_gap_b", 32'(hi[2] - hi[1]), 32'd4);
        end
        sc = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, '0);
            sc += int'(step);
        end
        chk("step_frozen", 32'(sc), 32'd0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, '0);

        // 3: ramp up to 3
        tick(1'b0, 1'b1, 1'b1, 4'd3);
        chk("up_busy_after_accept",  32'(busy), 32'd1);
        chk("up_ready_after_accept", 32'(tif.target_ready), 32'd0);
        last = int'(duty);
        n = 0;
        while (m_mode != 0 && n < 200) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            if (int'(duty) != last) chg.push_back(n);
            last = int'(duty);
            n++;
        end
        chk("up_ready_end", 32'(tif.target_ready), 32'd1);
        chk("up_duty_end",  32'(duty), 32'd3);
        chk("up_changes",   32'(chg.size()), 32'd3);
        if (chg.size() == 3) begin
            chk("up_spacing_a", 32'(chg[1] - chg[0]), 32'd8);
            chk("up_spacing_b", 32'(chg[2] - chg[1]), 32'd8);
        end

        // 4: down, equal target, full scale
        run_ramp("down0", 4'd0, 200, bs, mj, dn);
        chk("down0_busy_seen", 32'(bs), 32'd1);
        run_ramp("eq0", 4'd0, 20, bs, mj, dn);
        chk("eq0_no_busy",   32'(bs), 32'd0);
        chk("eq0_done_next", 32'(dn), 32'd1);
        run_ramp("full_up", 4'd15, 400, bs, mj, dn);
        chk("full_up_no_wrap", 32'(mj), 32'd1);
        run_ramp("full_dn", 4'd0, 400, bs, mj, dn);
        chk("full_dn_no_wrap", 32'(mj), 32'd1);

        // 5: held valid through a ramp plus ena freeze mid-ramp
        tick(1'b0, 1'b1, 1'b1, 4'd5);
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b1, 1'b1, 4'd9);
        last = int'(duty);
        sc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b1, 4'd9);
            sc += int'(busy);
        end
        chk("freeze_busy", 32'(sc), 32'd20);
        chk("freeze_duty", 32'(duty), 32'(last));
        n = 0; ready_cnt = 0;
        while (!(m_mode == 0 && m_duty == 9) && n < 400) begin
            tick(1'b0, 1'b1, 1'b1, 4'd9);
            ready_cnt += int'(tif.target_ready);
            n++;
        end
        chk("held_ready_cycles", 32'(ready_cnt), 32'd2);
        chk("held_duty", 32'(duty), 32'd9);
        tick(1'b0, 1'b1, 1'b0, '0);

        // 6: reset mid-ramp at duty=2
        run_ramp("to0", 4'd0, 400, bs, mj, dn);
        tick(1'b0, 1'b1, 1'b1, 4'd6);
        n = 0;
        while (m_duty != 2 && n < 200) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            n++;
        end
        chk("mid_duty2", 32'(duty), 32'd2);
        tick(1'b1, 1'b1, 1'b0, '0);
        chk("midrst_duty",  32'(duty), 32'd0);
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_step",  32'(step), 32'd0);
        chk("midrst_ready", 32'(tif.target_ready), 32'd1);

        // 7: randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 599) == 0),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 3) == 0),
                 N'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
